pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the IF/ID/EX front end. Watches the decode stage's
//  source registers and EX-stage status, then drives the decoder's pause input
//  and the EX bubble, hold and flush controls. It resolves load-use hazards,
//  multi-cycle mul/div waits, and branch/jump/trap redirects. It replaces the
//  decoder's ad-hoc post-jump countdown with one arbitrated scheduler.
// PARAMETERS
//  FLUSH_CYCLES     2   total cycles flush_o is high per redirect, incl. redirect cycle (>=1)
//  LOAD_USE_STALL   1   pause cycles inserted per load-use hazard (>=1)
//  MULDIV_MAX       70  watchdog limit, in cycles, for one mul/div op
//  PERF_W           32  width of the stall-cycle counter
// PORTS
//  clk_sys_i          in   1       system clock
//  rst_n_i            in   1       asynchronous reset, active low
//  id_rs1_addr_i      in   5       rs1 of the instruction in ID
//  id_rs2_addr_i      in   5       rs2 of the instruction in ID
//  id_rs1_used_i      in   1       ID instruction reads rs1
//  id_rs2_used_i      in   1       ID instruction reads rs2
//  ex_valid_i         in   1       EX holds a real instruction (not a bubble)
//  ex_rd_i            in   5       EX destination register
//  ex_is_load_i       in   1       EX instruction is a load
//  ex_muldiv_start_i  in   1       EX launches a multi-cycle mul/div this cycle
//  ex_muldiv_done_i   in   1       mul/div result valid this cycle
//  ex_redirect_i      in   1       taken branch/JAL/JALR resolved in EX
//  trap_i             in   1       ecall/exception commit, forces redirect
//  pause_o            out  1       hold PC and IF/ID register (to ID pause_i)
//  bubble_o           out  1       load NOP into ID/EX instead of ID output
//  ex_hold_o          out  1       freeze EX/MEM registers
//  flush_o            out  1       squash IF/ID and ID/EX contents
//  muldiv_kill_o      out  1       abort the in-flight mul/div
//  err_o              out  1       sticky: mul/div watchdog expired
//  stall_cnt_o        out  PERF_W  count of cycles with pause_o=1
// BEHAVIOUR
//  - Reset: state=RUN, counters=0, err_o=0, stall_cnt_o=0. All combinational
//    outputs are 0 while in RUN with idle inputs.
//  - Hazard term: lu = ex_valid_i & ex_is_load_i & (ex_rd_i!=0) &
//    ((id_rs1_used_i & rs1==rd) | (id_rs2_used_i & rs2==rd)).
//  - Outputs are Mealy (same cycle as cause). State and counters are registered.
//  - Priority in every state: trap_i > ex_redirect_i > muldiv > load-use.
//  - RUN
//    * trap/redirect: flush_o=1. Go to FLUSH with cnt=FLUSH_CYCLES-1, or stay
//      in RUN if that value is 0.
//    * ex_muldiv_start_i: pause_o=ex_hold_o=0 this cycle; go to MDWAIT, wdog=0.
//    * lu: pause_o=bubble_o=1. Go to LDSTALL with cnt=LOAD_USE_STALL-1, or
//      stay in RUN if that value is 0.
//  - LDSTALL: pause_o=bubble_o=1. Decrement cnt; go to RUN when cnt==0.
//  - MDWAIT
//    * pause_o=ex_hold_o=bubble_o=0 stays clear only when ex_muldiv_done_i=1;
//      otherwise pause_o=ex_hold_o=1.
//    * done: return to RUN; the next ID instruction advances in the same cycle.
//    * wdog==MULDIV_MAX-1 without done: err_o<=1 (sticky until reset),
//      muldiv_kill_o=1, return to RUN.
//    * trap_i: muldiv_kill_o=1, flush_o=1, go to FLUSH. ex_redirect_i is
//      ignored here because EX is frozen.
//  - FLUSH: flush_o=1, pause_o=0. Decrement cnt; go to RUN when cnt==0.
//    * A new redirect or trap reloads cnt=FLUSH_CYCLES-1.
//    * lu and muldiv_start are ignored (the flushed slots are invalid).
//  - stall_cnt_o increments each cycle pause_o=1 and saturates at all-ones.
//  - Reset mid-operation: returns to RUN immediately. No kill pulse is emitted;
//    the mul/div unit resets alongside.
//  - ex_muldiv_done_i outside MDWAIT is ignored.
// STRUCTURE
//  - Add to QianTang_header.v:
//    * state encodings HZ_RUN/HZ_LDSTALL/HZ_MDWAIT/HZ_FLUSH (2 bits)
//    * defaults for FLUSH_CYCLES and MULDIV_MAX
//  - Single module, no sub-module. One shared down-counter serves LDSTALL and
//    FLUSH; a separate up-counter is the watchdog.
// TESTING
//  1. lw x5 in EX, ID "add x6,x5,x1" (rs1 used): pause_o=bubble_o=1 for exactly
//     1 cycle, stall_cnt_o=1. Repeat with rd=x0: no stall.
//  2. ex_redirect_i pulse in RUN, FLUSH_CYCLES=2: flush_o high 2 cycles, then 0.
//     Second redirect in cycle 2: flush_o stays high 2 more cycles.
//  3. muldiv_start, done after 34 cycles: pause_o=ex_hold_o=1 for 33 cycles,
//     0 on the done cycle, state back to RUN, stall_cnt_o=33.
//  4. muldiv_start with no done, MULDIV_MAX=70: err_o rises after 70 cycles with a
//     1-cycle muldiv_kill_o, then RUN. err_o stays 1 until rst_n_i.
//  5. trap_i and lu and ex_redirect_i in the same cycle: flush_o=1, bubble_o=0,
//     pause_o=0. Then trap_i during MDWAIT: muldiv_kill_o=1 and flush_o=1 together.
//  6. rst_n_i dropped mid-LDSTALL (LOAD_USE_STALL=3): all outputs 0
//     asynchronously. After release, RUN with stall_cnt_o=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types, defaults and helpers for the IF/ID/EX hazard sequencer.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_ADDR_W         = 5;
  localparam int unsigned FLUSH_CYCLES_DEF   = 2;
  localparam int unsigned LOAD_USE_STALL_DEF = 1;
  localparam int unsigned MULDIV_MAX_DEF     = 70;
  localparam int unsigned PERF_W_DEF         = 32;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_LDSTALL = 2'd1,
    HZ_MDWAIT  = 2'd2,
    HZ_FLUSH   = 2'd3
  } hz_state_e;

  // Source operands of the instruction sitting in ID
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic                  rs1_used;
    logic                  rs2_used;
  } id_src_t;

  // Destination status of the instruction sitting in EX
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } ex_dst_t;

  // A load in EX writes a register that ID reads next cycle; x0 never hazards
  function automatic logic load_use_hazard(input id_src_t id, input ex_dst_t ex);
    logic rs1_hit;
    logic rs2_hit;
    rs1_hit = id.rs1_used && (id.rs1_addr == ex.rd);
    rs2_hit = id.rs2_used && (id.rs2_addr == ex.rd);
    return ex.valid && ex.is_load && (ex.rd != '0) && (rs1_hit || rs2_hit);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// Arbitrated pipeline sequencer: load-use stalls, mul/div waits with a
// watchdog, and branch/jump/trap flushes. Control outputs are Mealy.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES   = FLUSH_CYCLES_DEF,
  parameter int unsigned LOAD_USE_STALL = LOAD_USE_STALL_DEF,
  parameter int unsigned MULDIV_MAX     = MULDIV_MAX_DEF,
  parameter int unsigned PERF_W         = PERF_W_DEF
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_n_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic                  id_rs1_used_i,
  input  logic                  id_rs2_used_i,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_is_load_i,
  input  logic                  ex_muldiv_start_i,
  input  logic                  ex_muldiv_done_i,
  input  logic                  ex_redirect_i,
  input  logic                  trap_i,
  output logic                  pause_o,
  output logic                  bubble_o,
  output logic                  ex_hold_o,
  output logic                  flush_o,
  output logic                  muldiv_kill_o,
  output logic                  err_o,
  output logic [PERF_W-1:0]     stall_cnt_o
);

  // Shared down-counter only ever holds a reload value minus one
  localparam int unsigned CNT_MAX  = (FLUSH_CYCLES > LOAD_USE_STALL) ? FLUSH_CYCLES : LOAD_USE_STALL;
  localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned WDOG_W   = (MULDIV_MAX > 1) ? $clog2(MULDIV_MAX) : 1;

  localparam logic [CNT_W-1:0]  FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LU_RELOAD    = CNT_W'(LOAD_USE_STALL - 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST    = WDOG_W'(MULDIV_MAX - 1);

  // Single-cycle windows stay in RUN instead of entering a counting state
  localparam hz_state_e REDIR_TGT = (FLUSH_CYCLES > 1)   ? HZ_FLUSH   : HZ_RUN;
  localparam hz_state_e LU_TGT    = (LOAD_USE_STALL > 1) ? HZ_LDSTALL : HZ_RUN;

  hz_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_dec;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
  logic [PERF_W-1:0] stall_cnt_q;

  logic pause_c, bubble_c, hold_c, flush_c, kill_c;
  logic redirect_any, lu;

  id_src_t id_src;
  ex_dst_t ex_dst;

  // Bundle decode/execute status for the hazard check
  assign id_src = '{rs1_addr: id_rs1_addr_i, rs2_addr: id_rs2_addr_i,
                    rs1_used: id_rs1_used_i, rs2_used: id_rs2_used_i};
  assign ex_dst = '{valid: ex_valid_i, rd: ex_rd_i, is_load: ex_is_load_i};

  assign lu           = load_use_hazard(id_src, ex_dst);
  assign redirect_any = trap_i | ex_redirect_i;
  assign cnt_dec      = cnt_q - CNT_W'(1);

  // Next-state and Mealy control decode; trap > redirect > mul/div > load-use
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wdog_d   = wdog_q;
    err_d    = err_q;
    pause_c  = 1'b0;
    bubble_c = 1'b0;
    hold_c   = 1'b0;
    flush_c  = 1'b0;
    kill_c   = 1'b0;

    unique case (state_q)
      HZ_RUN: begin
        if (redirect_any) begin
          flush_c = 1'b1;
          cnt_d   = FLUSH_RELOAD;
          state_d = REDIR_TGT;
        end else if (ex_muldiv_start_i) begin
          wdog_d  = '0;
          state_d = HZ_MDWAIT;
        end else if (lu) begin
          pause_c  = 1'b1;
          bubble_c = 1'b1;
          cnt_d    = LU_RELOAD;
          state_d  = LU_TGT;
        end
      end

      HZ_LDSTALL: begin
        if (redirect_any) begin
          flush_c = 1'b1;
          cnt_d   = FLUSH_RELOAD;
          state_d = REDIR_TGT;
        end else begin
          pause_c  = 1'b1;
          bubble_c = 1'b1;
          cnt_d    = cnt_dec;
          if (cnt_dec == '0) state_d = HZ_RUN;
        end
      end

      HZ_MDWAIT: begin
        // EX is frozen here, so only a trap can interrupt the wait
        if (trap_i) begin
          kill_c  = 1'b1;
          flush_c = 1'b1;
          cnt_d   = FLUSH_RELOAD;
          state_d = REDIR_TGT;
        end else if (ex_muldiv_done_i) begin
          state_d = HZ_RUN;
        end else begin
          pause_c = 1'b1;
          hold_c  = 1'b1;
          if (wdog_q == WDOG_LAST) begin
            kill_c  = 1'b1;
            err_d   = 1'b1;
            state_d = HZ_RUN;
          end else begin
            wdog_d = wdog_q + WDOG_W'(1);
          end
        end
      end

      HZ_FLUSH: begin
        flush_c = 1'b1;
        if (redirect_any) begin
          cnt_d = FLUSH_RELOAD;
        end else begin
          cnt_d = cnt_dec;
          if (cnt_dec == '0) state_d = HZ_RUN;
        end
      end

      default: state_d = HZ_RUN;
    endcase
  end

  // State, shared counter, watchdog and sticky error
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // Saturating count of paused cycles
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= '0;
    end else if (pause_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end
  end

  // Controls are forced low while reset is held, independent of inputs
  assign pause_o       = pause_c  & rst_n_i;
  assign bubble_o      = bubble_c & rst_n_i;
  assign ex_hold_o     = hold_c   & rst_n_i;
  assign flush_o       = flush_c  & rst_n_i;
  assign muldiv_kill_o = kill_c   & rst_n_i;
  assign err_o         = err_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: two instances (single- and triple-cycle load-use
// stall, wide and narrow stall counter) share stimulus and are compared
// every cycle against a window/countdown model of the sequencer.
module tb_pipe_hazard_ctrl;

  localparam int FC    = 2;
  localparam int MDMAX = 70;

  logic       clk_sys_i = 1'b0;
  logic       rst_n_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_i;
  logic       id_rs1_used_i, id_rs2_used_i;
  logic       ex_valid_i, ex_is_load_i;
  logic       ex_muldiv_start_i, ex_muldiv_done_i, ex_redirect_i, trap_i;

  logic        pause_w [2];
  logic        bubble_w[2];
  logic        hold_w  [2];
  logic        flush_w [2];
  logic        kill_w  [2];
  logic        err_w   [2];
  logic [31:0] stall0;
  logic [3:0]  stall1;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk_sys_i = ~clk_sys_i;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .LOAD_USE_STALL(1), .MULDIV_MAX(MDMAX), .PERF_W(32)) u_dut0 (
    .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_valid_i(ex_valid_i), .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
    .ex_muldiv_start_i(ex_muldiv_start_i), .ex_muldiv_done_i(ex_muldiv_done_i),
    .ex_redirect_i(ex_redirect_i), .trap_i(trap_i),
    .pause_o(pause_w[0]), .bubble_o(bubble_w[0]), .ex_hold_o(hold_w[0]),
    .flush_o(flush_w[0]), .muldiv_kill_o(kill_w[0]), .err_o(err_w[0]),
    .stall_cnt_o(stall0)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .LOAD_USE_STALL(3), .MULDIV_MAX(MDMAX), .PERF_W(4)) u_dut1 (
    .clk_sys_i(clk_sys_i), .rst_n_i(rst_n_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_valid_i(ex_valid_i), .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i),
    .ex_muldiv_start_i(ex_muldiv_start_i), .ex_muldiv_done_i(ex_muldiv_done_i),
    .ex_redirect_i(ex_redirect_i), .trap_i(trap_i),
    .pause_o(pause_w[1]), .bubble_o(bubble_w[1]), .ex_hold_o(hold_w[1]),
    .flush_o(flush_w[1]), .muldiv_kill_o(kill_w[1]), .err_o(err_w[1]),
    .stall_cnt_o(stall1)
  );

  // One comparison; reports and counts a miss
  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t actual=%0d required=%0d", name, k, $time, act, exp);
    end
  endtask

  // Model: remaining flush slots, remaining extra stall slots, mul/div age
  int              m_flush[2];
  int              m_stall[2];
  int              m_age  [2];
  bit              m_md   [2];
  bit              m_err  [2];
  longint unsigned m_cnt  [2];
  int              lus    [2] = '{1, 3};
  longint unsigned cmax   [2] = '{64'hFFFF_FFFF, 64'd15};

  bit e_p, e_b, e_h, e_f, e_k, lu, redir;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_flush[k] = 0; m_stall[k] = 0; m_age[k] = 0;
      m_md[k] = 1'b0; m_err[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  // Every cycle: compare both instances to the model, then advance the model
  always @(negedge clk_sys_i) begin
    if (chk_en) begin
      lu = ex_valid_i && ex_is_load_i && (ex_rd_i != 5'd0) &&
           ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_i)) ||
            (id_rs2_used_i && (id_rs2_addr_i == ex_rd_i)));
      redir = trap_i || ex_redirect_i;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n_i) model_reset();
        chk("err", k, 64'(err_w[k]), 64'(m_err[k]));
        chk("stall_cnt", k, (k == 0) ? 64'(stall0) : 64'(stall1), 64'(m_cnt[k]));
        {e_p, e_b, e_h, e_f, e_k} = 5'b0;
        if (rst_n_i) begin
          if (m_md[k]) begin
            if (trap_i) begin
              e_k = 1; e_f = 1; m_md[k] = 0; m_flush[k] = FC - 1;
            end else if (ex_muldiv_done_i) begin
              m_md[k] = 0;
            end else begin
              e_p = 1; e_h = 1;
              if (m_age[k] == MDMAX - 1) begin
                e_k = 1; m_err[k] = 1; m_md[k] = 0;
              end else begin
                m_age[k]++;
              end
            end
          end else if (m_flush[k] > 0) begin
            e_f = 1;
            m_flush[k] = redir ? FC - 1 : m_flush[k] - 1;
          end else if (redir) begin
            e_f = 1; m_stall[k] = 0; m_flush[k] = FC - 1;
          end else if (m_stall[k] > 0) begin
            e_p = 1; e_b = 1; m_stall[k]--;
          end else if (ex_muldiv_start_i) begin
            m_md[k] = 1; m_age[k] = 0;
          end else if (lu) begin
            e_p = 1; e_b = 1; m_stall[k] = lus[k] - 1;
          end
          if (e_p && m_cnt[k] < cmax[k]) m_cnt[k]++;
        end
        chk("pause",  k, 64'(pause_w[k]),  64'(e_p));
        chk("bubble", k, 64'(bubble_w[k]), 64'(e_b));
        chk("hold",   k, 64'(hold_w[k]),   64'(e_h));
        chk("flush",  k, 64'(flush_w[k]),  64'(e_f));
        chk("kill",   k, 64'(kill_w[k]),   64'(e_k));
      end
    end
  end

  task automatic idle();
    id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; ex_rd_i = 5'd0;
    id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
    ex_valid_i = 1'b0; ex_is_load_i = 1'b0;
    ex_muldiv_start_i = 1'b0; ex_muldiv_done_i = 1'b0;
    ex_redirect_i = 1'b0; trap_i = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    idle();
    cycle();
    rst_n_i = 1'b1;
  endtask

  // lw x5 in EX, ID reads x5 via rs1
  task automatic set_lu(input logic [4:0] rd);
    ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_rd_i = rd;
    id_rs1_addr_i = rd; id_rs1_used_i = 1'b1;
    id_rs2_addr_i = 5'd1; id_rs2_used_i = 1'b1;
  endtask

  int trap_pct, redir_pct, start_pct, done_pct;

  initial begin
    rst_n_i = 1'b0;
    idle();
    chk_en = 1'b1;
    repeat (3) cycle();
    chk("rst_pause", 0, 64'(pause_w[0]), 64'd0);
    chk("rst_stall", 0, 64'(stall0), 64'd0);
    rst_n_i = 1'b1;
    cycle();

    // load-use: one pause on dut0, three on dut1; x0 never stalls
    set_lu(5'd5);
    #1 chk("lu_pause", 0, 64'(pause_w[0]), 64'd1);
    chk("lu_bubble", 0, 64'(bubble_w[0]), 64'd1);
    cycle();
    idle();
    #1 chk("lu_end", 0, 64'(pause_w[0]), 64'd0);
    chk("lu_cnt", 0, 64'(stall0), 64'd1);
    chk("lu3_mid", 1, 64'(pause_w[1]), 64'd1);
    repeat (3) cycle();
    set_lu(5'd0);
    #1 chk("lu_x0", 0, 64'(pause_w[0]), 64'd0);
    cycle();

    // redirect flush window, then re-armed by a second redirect
    do_reset();
    ex_redirect_i = 1'b1;
    #1 chk("rd_c0", 0, 64'(flush_w[0]), 64'd1);
    cycle();
    ex_redirect_i = 1'b0;
    #1 chk("rd_c1", 0, 64'(flush_w[0]), 64'd1);
    cycle();
    #1 chk("rd_c2", 0, 64'(flush_w[0]), 64'd0);
    ex_redirect_i = 1'b1;
    cycle();
    cycle();
    ex_redirect_i = 1'b0;
    #1 chk("rd2_ext", 0, 64'(flush_w[0]), 64'd1);
    cycle();
    #1 chk("rd2_end", 0, 64'(flush_w[0]), 64'd0);

    // mul/div finishing after 34 cycles
    do_reset();
    ex_muldiv_start_i = 1'b1;
    #1 chk("md_start", 0, 64'(pause_w[0]), 64'd0);
    cycle();
    ex_muldiv_start_i = 1'b0;
    repeat (33) cycle();
    ex_muldiv_done_i = 1'b1;
    #1 chk("md_done_hold", 0, 64'(hold_w[0]), 64'd0);
    cycle();
    ex_muldiv_done_i = 1'b0;
    #1 chk("md_cnt", 0, 64'(stall0), 64'd33);

    // mul/div watchdog
    do_reset();
    ex_muldiv_start_i = 1'b1;
    cycle();
    ex_muldiv_start_i = 1'b0;
    repeat (69) cycle();
    #1 chk("wd_kill", 0, 64'(kill_w[0]), 64'd1);
    chk("wd_err_pre", 0, 64'(err_w[0]), 64'd0);
    cycle();
    #1 chk("wd_err", 0, 64'(err_w[0]), 64'd1);
    chk("wd_cnt", 0, 64'(stall0), 64'd70);
    repeat (5) cycle();
    chk("wd_sticky", 0, 64'(err_w[0]), 64'd1);

    // trap + redirect + load-use together, then trap during a mul/div wait
    do_reset();
    set_lu(5'd7);
    trap_i = 1'b1; ex_redirect_i = 1'b1;
    #1 chk("pri_flush", 0, 64'(flush_w[0]), 64'd1);
    chk("pri_bubble", 0, 64'(bubble_w[0]), 64'd0);
    chk("pri_pause", 0, 64'(pause_w[0]), 64'd0);
    cycle();
    idle();
    cycle();
    ex_muldiv_start_i = 1'b1;
    cycle();
    ex_muldiv_start_i = 1'b0;
    repeat (4) cycle();
    trap_i = 1'b1;
    #1 chk("mdtrap_kill", 0, 64'(kill_w[0]), 64'd1);
    chk("mdtrap_flush", 0, 64'(flush_w[0]), 64'd1);
    cycle();
    idle();
    repeat (2) cycle();

    // asynchronous reset in the middle of a 3-cycle stall
    do_reset();
    set_lu(5'd3);
    cycle();
    #2 rst_n_i = 1'b0;
    #1 chk("arst_pause", 1, 64'(pause_w[1]), 64'd0);
    chk("arst_bubble", 1, 64'(bubble_w[1]), 64'd0);
    chk("arst_cnt", 1, 64'(stall1), 64'd0);
    cycle();
    rst_n_i = 1'b1;
    idle();
    cycle();
    #1 chk("arst_run", 1, 64'(pause_w[1]), 64'd0);
    chk("arst_cnt2", 1, 64'(stall1), 64'd0);

    // randomized traffic; the middle segment starves mul/div of done
    for (int i = 0; i < 6000; i++) begin
      if (i >= 2000 && i < 3500) begin
        trap_pct = 1; redir_pct = 2; start_pct = 10; done_pct = 0;
      end else begin
        trap_pct = 3; redir_pct = 8; start_pct = 8; done_pct = 20;
      end
      rst_n_i           = ($urandom_range(0, 399) != 0);
      trap_i            = ($urandom_range(0, 99) < trap_pct);
      ex_redirect_i     = ($urandom_range(0, 99) < redir_pct);
      ex_muldiv_start_i = ($urandom_range(0, 99) < start_pct);
      ex_muldiv_done_i  = ($urandom_range(0, 99) < done_pct);
      ex_valid_i        = ($urandom_range(0, 99) < 75);
      ex_is_load_i      = ($urandom_range(0, 99) < 50);
      ex_rd_i           = 5'($urandom_range(0, 3));
      id_rs1_addr_i     = 5'($urandom_range(0, 3));
      id_rs2_addr_i     = 5'($urandom_range(0, 3));
      id_rs1_used_i     = ($urandom_range(0, 99) < 70);
      id_rs2_used_i     = ($urandom_range(0, 99) < 50);
      cycle();
    end

    idle();
    rst_n_i = 1'b1;
    cycle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
